// File: rtl/rv32i_pkg.sv
// Shared RV32I branch/jump constants and the resolver state encoding.
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Low target bits that must be zero for a 4-byte aligned instruction fetch.
  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } resolver_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Maps B-type funct3 plus comparator flags to a taken decision and comparator signedness.
module branch_cond_eval
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken_c,
  output logic       bad_funct3_c,
  output logic       branch_op_c
);

  // Condition decode; only the unsigned compares select unsigned mode.
  always_comb begin
    taken_c      = 1'b0;
    bad_funct3_c = 1'b0;
    branch_op_c  = 1'b1;
    case (funct3)
      F3_BEQ:  taken_c = br_eq;
      F3_BNE:  taken_c = !br_eq;
      F3_BLT:  taken_c = br_lt;
      F3_BGE:  taken_c = !br_lt;
      F3_BLTU: begin
        taken_c     = br_lt;
        branch_op_c = 1'b0;
      end
      F3_BGEU: begin
        taken_c     = !br_lt;
        branch_op_c = 1'b0;
      end
      default: bad_funct3_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch/jump resolver: decides taken, issues a handshaked PC redirect, then flushes.
module branch_resolver #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_is_branch,
  input  logic                  i_is_jal,
  input  logic                  i_is_jalr,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  output logic                  BranchOp,
  input  logic                  BrEq,
  input  logic                  BrLT,
  output logic                  o_resolved,
  output logic                  o_taken,
  output logic [DATA_WIDTH-1:0] o_link,
  output logic                  o_link_we,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  input  logic                  i_redirect_ready,
  output logic                  o_flush,
  output logic                  o_misalign,
  output logic                  o_illegal
);

  import rv32i_pkg::*;

  resolver_state_e       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  resolved_d, taken_d, link_we_d, redirect_valid_d;
  logic                  flush_d, misalign_d, illegal_d;
  logic [DATA_WIDTH-1:0] link_d, redirect_pc_d;

  logic                  cond_taken_c, bad_funct3_c;
  logic                  type_onehot_c, jump_c, taken_c, aligned_c;
  logic [DATA_WIDTH-1:0] pc_rel_c, jalr_sum_c, target_c;

  branch_cond_eval u_cond (
    .funct3       (i_funct3),
    .br_eq        (BrEq),
    .br_lt        (BrLT),
    .taken_c      (cond_taken_c),
    .bad_funct3_c (bad_funct3_c),
    .branch_op_c  (BranchOp)
  );

  // Type decode, target arithmetic and alignment check for the presented instruction.
  always_comb begin
    type_onehot_c = (i_is_branch ^ i_is_jal ^ i_is_jalr) & !(i_is_branch & i_is_jal & i_is_jalr);
    jump_c        = i_is_jal | i_is_jalr;
    pc_rel_c      = i_pc + i_imm;
    jalr_sum_c    = i_rs1 + i_imm;
    target_c      = i_is_jalr ? {jalr_sum_c[DATA_WIDTH-1:1], 1'b0} : pc_rel_c;
    taken_c       = jump_c | (i_is_branch & cond_taken_c);
    aligned_c     = (target_c[1:0] & INSTR_ALIGN_MASK) == 2'b00;
  end

  assign o_ready = (state_q == IDLE);

  // Next-state and next registered-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    resolved_d       = 1'b0;
    taken_d          = 1'b0;
    link_we_d        = 1'b0;
    flush_d          = 1'b0;
    misalign_d       = 1'b0;
    illegal_d        = 1'b0;
    link_d           = o_link;
    redirect_valid_d = o_redirect_valid;
    redirect_pc_d    = o_redirect_pc;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!type_onehot_c || (i_is_branch && bad_funct3_c)) begin
            illegal_d = 1'b1;
          end else begin
            resolved_d = 1'b1;
            if (jump_c) begin
              link_we_d = 1'b1;
              link_d    = i_pc + DATA_WIDTH'(4);
            end
            if (taken_c) begin
              if (!aligned_c) begin
                misalign_d = 1'b1;
              end else begin
                taken_d          = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target_c;
                state_d          = REDIRECT;
              end
            end
          end
        end
      end
      REDIRECT: begin
        if (i_redirect_ready) begin
          redirect_valid_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES);
            flush_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      o_resolved       <= 1'b0;
      o_taken          <= 1'b0;
      o_link           <= '0;
      o_link_we        <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_flush          <= 1'b0;
      o_misalign       <= 1'b0;
      o_illegal        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      o_resolved       <= resolved_d;
      o_taken          <= taken_d;
      o_link           <= link_d;
      o_link_we        <= link_we_d;
      o_redirect_valid <= redirect_valid_d;
      o_redirect_pc    <= redirect_pc_d;
      o_flush          <= flush_d;
      o_misalign       <= misalign_d;
      o_illegal        <= illegal_d;
    end
  end

endmodule
